sd_init_sequencer: RTL and testbench

Sequences the SD card SPI-mode bring-up and block-read commands through the single-command engine (`sd_cmd`). After reset it performs power-up clocking and then the CMD0 → CMD8 → (CMD55/ACMD41 loop) → CMD58 flow. It then serves one-at-a-time 32-bit read requests (CMD17) from the rest of the design. It owns `cmd_start` and therefore sole access to the command engine.

---
 rtl/sd_init_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_sd_init_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_init_sequencer.sv
// SD card SPI-mode bring-up and single-block read sequencer driving the sd_cmd engine.
// Every command runs as an ISSUE phase (cmd_start high) followed by exactly one GAP cycle.
module sd_init_sequencer #(
    parameter int unsigned POWERUP_CYCLES = 80,
    parameter int unsigned ACMD41_RETRIES = 1000,
    parameter int unsigned CMD_TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reinit,
    output logic        cs_n,
    output logic [7:0]  cmd_number,
    output logic [31:0] cmd_args,
    output logic [7:0]  cmd_crc,
    output logic        cmd_start,
    input  logic        cmd_done,
    input  logic [7:0]  cmd_resp,
    input  logic [31:0] cmd_data,
    output logic        init_done,
    output logic        init_error,
    output logic        card_hc,
    output logic        rd_ready,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_valid,
    output logic        rd_error,
    output logic [31:0] rd_data
);

    localparam int unsigned PW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
    localparam int unsigned TW = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        ST_POWERUP,
        ST_CMD0,
        ST_CMD8,
        ST_CMD55,
        ST_ACMD41,
        ST_CMD58,
        ST_IDLE,
        ST_READ,
        ST_ERROR
    } state_t;

    state_t state, state_next;
    state_t target, target_next;
    logic   gap, gap_next;

    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic [15:0]   acmd_cnt;
    logic [15:0]   acmd_inc;
    logic [31:0]   addr;
    logic [31:0]   read_arg;

    logic cmd_state;
    logic issue;
    logic timed_out;
    logic finish;
    logic accept;
    logic do_reinit;
    logic read_ok;
    logic cmd58_ok;

    assign cmd_state = state inside {ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD58, ST_READ};
    assign issue     = cmd_state && !gap;
    assign timed_out = issue && !cmd_done && (tcnt == TW'(CMD_TIMEOUT - 1));
    assign finish    = issue && (cmd_done || timed_out);
    assign acmd_inc  = acmd_cnt + 16'd1;
    assign accept    = (state == ST_IDLE) && rd_req && !reinit;
    assign do_reinit = reinit && ((state == ST_IDLE) || (state == ST_ERROR));
    assign read_ok   = (state == ST_READ) && issue && cmd_done && (cmd_resp == 8'h00);
    assign cmd58_ok  = (state == ST_CMD58) && issue && cmd_done && (cmd_resp == 8'h00);
    // Byte-addressed cards take the block number scaled by 512, truncated to 32 bits
    assign read_arg  = card_hc ? addr : {addr[22:0], 9'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_POWERUP;
            target <= ST_POWERUP;
            gap    <= 1'b0;
        end else begin
            state  <= state_next;
            target <= target_next;
            gap    <= gap_next;
        end
    end

    always_comb begin
        state_next  = state;
        target_next = target;
        gap_next    = gap;
        if (gap) begin
            state_next = target;
            gap_next   = 1'b0;
        end else begin
            case (state)
                ST_POWERUP: begin
                    if (pcnt == PW'(POWERUP_CYCLES - 1)) state_next = ST_CMD0;
                end
                ST_CMD0: begin
                    if (finish) begin
                        gap_next    = 1'b1;
                        target_next = (cmd_done && cmd_resp == 8'h01) ? ST_CMD8 : ST_ERROR;
                    end
                end
                ST_CMD8: begin
                    if (finish) begin
                        gap_next    = 1'b1;
                        target_next = (cmd_done && cmd_resp == 8'h01 && cmd_data[11:0] == 12'h1AA)
                                      ? ST_CMD55 : ST_ERROR;
                    end
                end
                ST_CMD55: begin
                    if (finish) begin
                        gap_next    = 1'b1;
                        target_next = (cmd_done && cmd_resp[7:1] == 7'd0) ? ST_ACMD41 : ST_ERROR;
                    end
                end
                ST_ACMD41: begin
                    if (finish) begin
                        gap_next = 1'b1;
                        if (cmd_done && cmd_resp == 8'h00)
                            target_next = ST_CMD58;
                        else if (cmd_done && cmd_resp == 8'h01 && acmd_inc < 16'(ACMD41_RETRIES))
                            target_next = ST_CMD55;
                        else
                            target_next = ST_ERROR;
                    end
                end
                ST_CMD58: begin
                    if (finish) begin
                        gap_next    = 1'b1;
                        target_next = cmd58_ok ? ST_IDLE : ST_ERROR;
                    end
                end
                ST_READ: begin
                    if (finish) begin
                        gap_next    = 1'b1;
                        target_next = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (reinit)      state_next = ST_POWERUP;
                    else if (rd_req) state_next = ST_READ;
                end
                ST_ERROR: begin
                    if (reinit) state_next = ST_POWERUP;
                end
                default: state_next = ST_ERROR;
            endcase
        end
    end

    always_comb begin
        cmd_number = '0;
        cmd_args   = '0;
        cmd_crc    = '0;
        case (state)
            ST_CMD0:   begin cmd_number = 8'h40; cmd_crc = 8'h95; end
            ST_CMD8:   begin cmd_number = 8'h48; cmd_args = 32'h0000_01AA; cmd_crc = 8'h87; end
            ST_CMD55:  begin cmd_number = 8'h77; cmd_crc = 8'h01; end
            ST_ACMD41: begin cmd_number = 8'h69; cmd_args = 32'h4000_0000; cmd_crc = 8'h01; end
            ST_CMD58:  begin cmd_number = 8'h7A; cmd_crc = 8'h01; end
            ST_READ:   begin cmd_number = 8'h51; cmd_args = read_arg; cmd_crc = 8'h01; end
            default:   ;
        endcase
        cmd_start = issue;
        cs_n      = (state == ST_POWERUP) || (state == ST_ERROR);
        rd_ready  = (state == ST_IDLE) && !reinit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt       <= '0;
            tcnt       <= '0;
            acmd_cnt   <= '0;
            addr       <= '0;
            card_hc    <= 1'b0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_error   <= 1'b0;
        end else begin
            pcnt     <= (state == ST_POWERUP) ? pcnt + 1'b1 : '0;
            tcnt     <= (issue && !finish) ? tcnt + 1'b1 : '0;
            rd_valid <= read_ok;
            rd_error <= (state == ST_READ) && finish && !read_ok;

            if (state == ST_CMD8 && finish && target_next == ST_CMD55)
                acmd_cnt <= '0;
            else if (state == ST_ACMD41 && issue && cmd_done)
                acmd_cnt <= acmd_inc;

            if (accept)  addr    <= rd_addr;
            if (read_ok) rd_data <= cmd_data;

            if (cmd58_ok) begin
                card_hc   <= cmd_data[30];
                init_done <= 1'b1;
            end

            if (gap && target == ST_ERROR) begin
                init_error <= 1'b1;
                init_done  <= 1'b0;
            end

            if (do_reinit) begin
                init_done  <= 1'b0;
                init_error <= 1'b0;
                card_hc    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Randomized bench for sd_init_sequencer: a scripted card/engine model answers each command,
// and expected command sequences and read results are derived from the card protocol rules.
module tb_sd_init_sequencer;

    localparam int unsigned PUP = 80;
    localparam int unsigned RETRIES = 4;
    localparam int unsigned TMO = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reinit;
    logic        cs_n;
    logic [7:0]  cmd_number;
    logic [31:0] cmd_args;
    logic [7:0]  cmd_crc;
    logic        cmd_start;
    logic        cmd_done;
    logic [7:0]  cmd_resp;
    logic [31:0] cmd_data;
    logic        init_done;
    logic        init_error;
    logic        card_hc;
    logic        rd_ready;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_valid;
    logic        rd_error;
    logic [31:0] rd_data;

    sd_init_sequencer #(
        .POWERUP_CYCLES(PUP),
        .ACMD41_RETRIES(RETRIES),
        .CMD_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .reinit(reinit), .cs_n(cs_n),
        .cmd_number(cmd_number), .cmd_args(cmd_args), .cmd_crc(cmd_crc),
        .cmd_start(cmd_start), .cmd_done(cmd_done), .cmd_resp(cmd_resp), .cmd_data(cmd_data),
        .init_done(init_done), .init_error(init_error), .card_hc(card_hc),
        .rd_ready(rd_ready), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_error(rd_error), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Card scenario knobs
    logic [7:0]  sc_r0;
    logic [7:0]  sc_r8;
    logic [31:0] sc_r8data;
    int unsigned sc_n41;
    logic [31:0] sc_ocr;
    logic [7:0]  sc_rd_resp;
    logic [31:0] sc_rd_word;
    bit          withhold;

    logic [7:0]  log_q[$];
    int unsigned gaps[$];
    logic [7:0]  exp_q[$];
    bit          exp_ok;
    logic [31:0] last_rd;
    logic        exp_hc;

    // Engine model: answers after 1..4 cycles, holds done until cmd_start drops
    initial begin : engine
        int unsigned lat;
        int unsigned lowrun;
        int unsigned acmd_seen;
        bit busy;
        logic [7:0] cur;
        cmd_done = 1'b0; cmd_resp = '0; cmd_data = '0;
        busy = 1'b0; lowrun = 0; acmd_seen = 0; lat = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (!cmd_start) begin
                cmd_done = 1'b0;
                busy = 1'b0;
                lowrun++;
            end else if (!busy) begin
                busy = 1'b1;
                cur = cmd_number;
                if (log_q.size() > 0) gaps.push_back(lowrun);
                lowrun = 0;
                log_q.push_back(cur);
                lat = $urandom_range(1, 4);
                case (cur)
                    8'h40: begin check("cmd0_args", cmd_args, 32'h0); check("cmd0_crc", cmd_crc, 8'h95); end
                    8'h48: begin check("cmd8_args", cmd_args, 32'h1AA); check("cmd8_crc", cmd_crc, 8'h87); end
                    8'h77: begin check("cmd55_args", cmd_args, 32'h0); check("cmd55_crc", cmd_crc, 8'h01); end
                    8'h69: begin check("acmd41_args", cmd_args, 32'h4000_0000); check("acmd41_crc", cmd_crc, 8'h01); end
                    8'h7A: begin check("cmd58_args", cmd_args, 32'h0); check("cmd58_crc", cmd_crc, 8'h01); end
                    8'h51: ;
                    default: check("cmd_number_legal", cur, 8'h40);
                endcase
            end
            if (busy && !cmd_done && !withhold) begin
                lat--;
                if (lat == 0) begin
                    cmd_data = '0;
                    case (cur)
                        8'h40: begin acmd_seen = 0; cmd_resp = sc_r0; end
                        8'h48: begin cmd_resp = sc_r8; cmd_data = sc_r8data; end
                        8'h77: cmd_resp = 8'h01;
                        8'h69: begin cmd_resp = (acmd_seen < sc_n41) ? 8'h01 : 8'h00; acmd_seen++; end
                        8'h7A: begin cmd_resp = 8'h00; cmd_data = sc_ocr; end
                        8'h51: begin cmd_resp = sc_rd_resp; cmd_data = sc_rd_word; end
                        default: cmd_resp = 8'hFF;
                    endcase
                    cmd_done = 1'b1;
                end
            end
        end
    end

    // Protocol rules: CMD0, CMD8, then CMD55/ACMD41 pairs until ready or retries exhausted, then CMD58
    task automatic build_expected();
        exp_q.delete();
        exp_ok = 1'b0;
        exp_q.push_back(8'h40);
        if (sc_r0 != 8'h01) return;
        exp_q.push_back(8'h48);
        if (!(sc_r8 == 8'h01 && sc_r8data[11:0] == 12'h1AA)) return;
        for (int unsigned k = 1; k <= RETRIES; k++) begin
            exp_q.push_back(8'h77);
            exp_q.push_back(8'h69);
            if (k > sc_n41) begin
                exp_q.push_back(8'h7A);
                exp_ok = 1'b1;
                return;
            end
        end
    endtask

    function automatic int unsigned count_cmd(input logic [7:0] c);
        int unsigned n = 0;
        foreach (log_q[i]) if (log_q[i] == c) n++;
        return n;
    endfunction

    // mode 0: release reset and time power-up; 1: pulse reinit; 2: reinit already taken
    task automatic run_init(input int mode, input logic [7:0] r0, input logic [7:0] r8,
                            input logic [31:0] r8d, input int unsigned n41, input logic [31:0] ocr);
        int unsigned n;
        int unsigned cs_bad;
        int unsigned bad_gaps;
        sc_r0 = r0; sc_r8 = r8; sc_r8data = r8d; sc_n41 = n41; sc_ocr = ocr;
        build_expected();
        log_q.delete();
        gaps.delete();
        if (mode == 0) begin
            @(negedge clk);
            rst_n = 1'b1;
            n = 0; cs_bad = 0;
            while (!cmd_start && n < 1000) begin
                @(posedge clk); #1;
                n++;
                if (!cmd_start && !cs_n) cs_bad++;
            end
            check("powerup_cycles", n, PUP);
            check("powerup_cs_n", cs_bad, 0);
            check("powerup_cmd0_num", cmd_number, 8'h40);
            check("powerup_cmd0_cs", cs_n, 1'b0);
        end else if (mode == 1) begin
            reinit = 1'b1;
            @(posedge clk); #1;
            reinit = 1'b0;
        end
        n = 0;
        while (!(init_done || init_error) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("init_finish_in_time", n < 3000, 1'b1);
        @(posedge clk); #1;
        exp_hc = exp_ok ? ocr[30] : 1'b0;
        check("init_done", init_done, exp_ok);
        check("init_error", init_error, !exp_ok);
        check("card_hc", card_hc, exp_hc);
        check("cs_n_after_init", cs_n, !exp_ok);
        check("cmd_count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check("cmd_seq", log_q[i], exp_q[i]);
        bad_gaps = 0;
        foreach (gaps[i]) if (gaps[i] != 1) bad_gaps++;
        check("gap_cycles", bad_gaps, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] resp,
                           input logic [31:0] word, input bit wh);
        int unsigned n;
        int unsigned hi;
        bit ok;
        n = 0;
        while (!rd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("rd_ready_wait", rd_ready, 1'b1);
        rd_req = 1'b1; rd_addr = addr;
        sc_rd_resp = resp; sc_rd_word = word; withhold = wh;
        @(posedge clk); #1;
        rd_req = 1'b0;
        rd_addr = $urandom;
        check("rd_ready_after_accept", rd_ready, 1'b0);
        check("read_cmd_start", cmd_start, 1'b1);
        check("read_cmd_num", cmd_number, 8'h51);
        check("read_cmd_args", cmd_args, exp_hc ? addr : addr * 32'd512);
        check("read_cmd_crc", cmd_crc, 8'h01);
        hi = 1;
        while (cmd_start && hi < 1000) begin
            @(posedge clk); #1;
            if (cmd_start) hi++;
        end
        if (wh) check("timeout_issue_cycles", hi, TMO);
        ok = !wh && (resp == 8'h00);
        if (ok) last_rd = word;
        check("rd_valid_pulse", rd_valid, ok);
        check("rd_error_pulse", rd_error, !ok);
        check("rd_data", rd_data, last_rd);
        check("rd_ready_in_gap", rd_ready, 1'b0);
        withhold = 1'b0;
        @(posedge clk); #1;
        check("rd_ready_back", rd_ready, 1'b1);
        check("rd_valid_one_cycle", rd_valid, 1'b0);
        check("rd_error_one_cycle", rd_error, 1'b0);
        check("init_done_kept", init_done, 1'b1);
    endtask

    initial begin
        int unsigned n;
        logic [7:0] r8;
        logic [31:0] r8d;
        rst_n = 1'b0; reinit = 1'b0; rd_req = 1'b0; rd_addr = '0;
        withhold = 1'b0; sc_rd_resp = '0; sc_rd_word = '0;
        sc_r0 = 8'h01; sc_r8 = 8'h01; sc_r8data = 32'h1AA; sc_n41 = 0; sc_ocr = '0;
        last_rd = '0; exp_hc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cs_n", cs_n, 1'b1);
        check("reset_cmd_start", cmd_start, 1'b0);
        check("reset_cmd_number", cmd_number, 8'h00);
        check("reset_cmd_args", cmd_args, 32'h0);
        check("reset_init_done", init_done, 1'b0);
        check("reset_init_error", init_error, 1'b0);
        check("reset_card_hc", card_hc, 1'b0);
        check("reset_rd_ready", rd_ready, 1'b0);
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_rd_error", rd_error, 1'b0);
        check("reset_rd_data", rd_data, 32'h0);

        // Nominal bring-up: ACMD41 busy twice, high-capacity card
        run_init(0, 8'h01, 8'h01, 32'h0000_01AA, 2, 32'hC0FF_8000);
        check("nominal_cmd55_count", count_cmd(8'h77), 3);
        check("nominal_acmd41_count", count_cmd(8'h69), 3);

        for (int i = 0; i < 4; i++)
            do_read($urandom, ($urandom_range(0, 2) == 0) ? 8'h04 : 8'h00, $urandom, 1'b0);
        do_read($urandom, 8'h00, $urandom, 1'b1);

        // reinit wins over a simultaneous read request
        rd_req = 1'b1; reinit = 1'b1; rd_addr = 32'h55;
        @(posedge clk); #1;
        rd_req = 1'b0; reinit = 1'b0;
        check("reinit_cmd_start", cmd_start, 1'b0);
        check("reinit_init_done", init_done, 1'b0);
        check("reinit_cs_n", cs_n, 1'b1);
        check("reinit_card_hc", card_hc, 1'b0);
        run_init(2, 8'h01, 8'h01, 32'h0000_01AA, $urandom_range(0, 2), 32'h8000_0000);

        do_read(32'h3, 8'h00, 32'hDEAD_BEEF, 1'b0);
        do_read(32'h3, 8'h04, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 3; i++)
            do_read($urandom, ($urandom_range(0, 1) == 0) ? 8'h04 : 8'h00, $urandom, 1'b0);
        do_read($urandom, 8'h00, $urandom, 1'b1);

        // v1 card and ACMD41 never ready
        run_init(1, 8'h01, 8'h05, 32'h0000_01AA, 0, 32'hC000_0000);
        run_init(1, 8'h01, 8'h01, 32'h0000_01AA, 100, 32'hC000_0000);
        check("retry_acmd41_count", count_cmd(8'h69), RETRIES);

        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 3))
                0:       begin r8 = 8'h05; r8d = 32'h1AA; end
                1:       begin r8 = 8'h01; r8d = 32'h2AA; end
                default: begin r8 = 8'h01; r8d = {$urandom_range(0, 1023), 12'h1AA}; end
            endcase
            run_init(1, ($urandom_range(0, 5) == 0) ? 8'h00 : 8'h01, r8, r8d,
                     $urandom_range(0, 5), $urandom);
        end

        // Asynchronous reset while ACMD41 is in flight
        sc_n41 = 50;
        reinit = 1'b1;
        @(posedge clk); #1;
        reinit = 1'b0;
        n = 0;
        while (!(cmd_start && cmd_number == 8'h69) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_acmd41", n < 2000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cmd_start", cmd_start, 1'b0);
        check("async_rst_cs_n", cs_n, 1'b1);
        repeat (2) @(posedge clk);
        run_init(0, 8'h01, 8'h01, 32'h0000_01AA, 1, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
